rf_scoreboard: RTL and testbench
================================

Name: rf_scoreboard

Overview:
- Tracks in-flight register writes between decode and writeback, and stalls decode on read-after-write hazards.
- Keeps a per-register pending-write counter: incremented when an instruction issues with a destination register, decremented when writeback completes.
- Sits beside the decoder and register file. Decode presents rs1/rs2/rd; writeback presents its rd.
- Provides stall and flush control so the register file is never read stale.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero.
- CNT_W, 2, width of each pending counter; maximum outstanding writes per register is 2^CNT_W-1.
- INFL_W, 7, width of the total in-flight count output; must hold (NREG-1)*(2^CNT_W-1).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- issue_valid  in  1  decode has an instruction presented this cycle
- issue_rs1  in  5  source register 1 of the issuing instruction
- issue_rs2  in  5  source register 2 of the issuing instruction
- use_rs1  in  1  instruction reads rs1
- use_rs2  in  1  instruction reads rs2
- issue_rd  in  5  destination register
- issue_wen  in  1  instruction writes rd
- wb_valid  in  1  writeback retires a register write this cycle
- wb_rd  in  5  destination of the retiring write
- flush  in  1  pipeline flush; all in-flight writes are cancelled
- stall  out  1  decode must hold; the instruction is not issued
- issue_fire  out  1  issue_valid & ~stall; the instruction is accepted
- pending_mask  out  NREG  bit i set when counter[i] != 0
- inflight  out  INFL_W  sum of all counters
- err_underflow  out  1  sticky; set when a writeback arrives for a register with no pending count

Behaviour:
- Reset:
  - All counters 0; pending_mask=0; inflight=0; err_underflow=0.
  - stall evaluates to 0 during and after reset while the counters are 0.
- Register 0:
  - Issue or writeback with rd=0 never changes counter[0]; counter[0] is constant 0.
  - Reads of register 0 never stall.
- Hazard check (combinational from current state plus the same-cycle writeback):
  - hz1 = use_rs1 & rs1!=0 & eff_cnt(rs1)!=0; hz2 defined the same way for rs2.
  - eff_cnt(r) = counter[r] - (wb_valid & wb_rd==r & counter[r]!=0).
  - Rationale: the register file writes combinationally, so a writeback in the same cycle is visible to the read. A counter at 1 that retires this cycle does not stall.
- Structural hazard: satf = issue_wen & issue_rd!=0 & counter[issue_rd]==max & !(wb_valid & wb_rd==issue_rd).
- Stall equation:
  - stall = issue_valid & (hz1 | hz2 | satf) & ~flush.
  - stall=0 whenever issue_valid=0.
- Counter update at the clock edge, in priority order:
  1. reset: all counters cleared.
  2. flush: all counters cleared; same-cycle issue and wb are ignored; err_underflow is unchanged.
  3. Otherwise, per register r:
     - inc = issue_fire & issue_wen & issue_rd==r & r!=0
     - dec = wb_valid & wb_rd==r & r!=0 & counter[r]!=0
     - counter[r] += inc - dec; inc and dec together give a net change of 0.
     - wb_valid for a register whose counter is 0: counter stays 0; err_underflow is set and held until reset.
- Self-dependency: an instruction with rs1==rd pending stalls on the source. An instruction with rs==rd not pending issues and increments the counter the same cycle; its own read is not blocked.
- Outputs:
  - pending_mask and inflight are registered, derived from the counter state; they update one cycle after issue_fire or wb.
  - inflight increments/decrements by the net of inc and dec each cycle; no overflow is possible given the INFL_W rule.
- Reset or flush mid-stall: stall drops in the following cycle once the counters are 0.
- No counter wraps: saturation is prevented by satf; underflow is prevented by the dec guard.

Decomposition:
- Shared package rv_pkg:
  - REG_ADDR_W=5, NREG=32, ZERO_REG=0.
  - typedef reg_addr_t.
  - Count-width constants.
- Sub-module sb_counter (one per register, generate loop):
  - Inputs: inc, dec, clr.
  - Outputs: CNT_W counter, nz, is_max.
- Top level holds: hazard compare, stall/fire logic, inflight accumulator, underflow flag.

Test Plan:
- Reset, then issue add rd=5 (issue_wen=1) with no sources -> issue_fire=1; next cycle pending_mask[5]=1, inflight=1.
- With counter[5]=1, issue rs1=5 with use_rs1=1 and no wb -> stall=1 held for 3 cycles. Then wb_valid with wb_rd=5 -> same cycle stall=0 and issue_fire=1; next cycle pending_mask[5]=0.
- Issue rd=7 three times, then a fourth issue with rd=7 and no wb -> stall=1 (satf), counter=3. Same fourth issue with wb_rd=7 -> issue_fire=1, counter stays 3.
- Issue rd=0, and issue rs1=0 with use_rs1=1 -> never stalls; pending_mask=0; inflight unchanged.
- Counters at rd 3 and rd 9 = 1 and 2, assert flush together with wb_rd=3 -> next cycle all counters 0, inflight=0, err_underflow=0.
- wb_valid with wb_rd=12 while counter[12]=0 -> err_underflow=1 and held until reset; counter[12] stays 0. Assert reset -> err_underflow=0.

Source files
------------

// File: rtl/rf_scoreboard_pkg.sv
// Shared constants and types for the register-file scoreboard.
// Sizes the register address, the per-register pending counters and the in-flight total.
package rf_scoreboard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DEF_NREG   = 32;
    localparam int DEF_CNT_W  = 2;
    localparam int DEF_INFL_W = 7;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    localparam reg_addr_t ZERO_REG = '0;

    // Largest possible sum over all writable registers; INFL_W must cover it.
    function automatic int infl_max(input int nreg, input int cnt_w);
        return (nreg - 1) * ((2 ** cnt_w) - 1);
    endfunction

endpackage

// File: rtl/rf_scoreboard_if.sv
// Decode/writeback-facing bundle of the scoreboard.
// The master side is the pipeline (decode, writeback, flush); the slave side is the scoreboard.
interface rf_scoreboard_if
    import rf_scoreboard_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int INFL_W = DEF_INFL_W
);
    logic              issue_valid;
    reg_addr_t         issue_rs1;
    reg_addr_t         issue_rs2;
    logic              use_rs1;
    logic              use_rs2;
    reg_addr_t         issue_rd;
    logic              issue_wen;
    logic              wb_valid;
    reg_addr_t         wb_rd;
    logic              flush;
    logic              stall;
    logic              issue_fire;
    logic [NREG-1:0]   pending_mask;
    logic [INFL_W-1:0] inflight;
    logic              err_underflow;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, use_rs1, use_rs2,
               issue_rd, issue_wen, wb_valid, wb_rd, flush,
        input  stall, issue_fire, pending_mask, inflight, err_underflow
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, use_rs1, use_rs2,
               issue_rd, issue_wen, wb_valid, wb_rd, flush,
        output stall, issue_fire, pending_mask, inflight, err_underflow
    );

endinterface

// File: rtl/rf_scoreboard_sb_counter.sv
// Pending-write counter for one architectural register.
// Callers guarantee inc never hits a full counter and dec never hits an empty one.
module rf_scoreboard_sb_counter
    import rf_scoreboard_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             nz,
    output logic             is_max
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign nz     = |cnt;
    assign is_max = &cnt;

endmodule

// File: rtl/rf_scoreboard.sv
// Read-after-write scoreboard between decode and writeback.
// Stalls decode on pending sources or a saturated destination counter; a same-cycle writeback counts as visible.
module rf_scoreboard
    import rf_scoreboard_pkg::*;
#(
    parameter int NREG   = DEF_NREG,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int INFL_W = DEF_INFL_W
) (
    input  logic         clk,
    input  logic         reset,
    rf_scoreboard_if.slave sb
);

    if (((2 ** INFL_W) - 1) < infl_max(NREG, CNT_W)) begin : g_infl_check
        $error("rf_scoreboard: INFL_W too narrow for NREG and CNT_W");
    end

    logic [CNT_W-1:0] cnt [NREG];
    logic [NREG-1:0]  nz;
    logic [NREG-1:0]  is_max;
    logic [NREG-1:0]  inc;
    logic [NREG-1:0]  dec;

    logic             hz1;
    logic             hz2;
    logic             satf;
    logic             stall_c;
    logic             fire;
    logic             inc_any;
    logic             dec_any;
    logic             underflow_hit;
    logic [INFL_W-1:0] inflight_q;
    logic             err_q;

    // Register 0 is hardwired zero: no counter, never pending.
    assign cnt[0]    = '0;
    assign nz[0]     = 1'b0;
    assign is_max[0] = 1'b0;
    assign inc[0]    = 1'b0;
    assign dec[0]    = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        assign inc[r] = fire && sb.issue_wen && (sb.issue_rd == REG_ADDR_W'(r));
        assign dec[r] = sb.wb_valid && (sb.wb_rd == REG_ADDR_W'(r)) && nz[r];

        rf_scoreboard_sb_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk    (clk),
            .reset  (reset),
            .clr    (sb.flush),
            .inc    (inc[r]),
            .dec    (dec[r]),
            .cnt    (cnt[r]),
            .nz     (nz[r]),
            .is_max (is_max[r])
        );
    end

    // The register file writes through, so a retiring write is already visible to this read.
    always_comb begin
        logic             hit1;
        logic             hit2;
        logic [CNT_W-1:0] eff1;
        logic [CNT_W-1:0] eff2;
        hit1 = sb.wb_valid && (sb.wb_rd == sb.issue_rs1) && nz[sb.issue_rs1];
        hit2 = sb.wb_valid && (sb.wb_rd == sb.issue_rs2) && nz[sb.issue_rs2];
        eff1 = cnt[sb.issue_rs1] - CNT_W'(hit1);
        eff2 = cnt[sb.issue_rs2] - CNT_W'(hit2);
        hz1  = sb.use_rs1 && (sb.issue_rs1 != ZERO_REG) && (eff1 != '0);
        hz2  = sb.use_rs2 && (sb.issue_rs2 != ZERO_REG) && (eff2 != '0);
        satf = sb.issue_wen && (sb.issue_rd != ZERO_REG) && is_max[sb.issue_rd]
               && !(sb.wb_valid && (sb.wb_rd == sb.issue_rd));
    end

    assign stall_c = sb.issue_valid && (hz1 || hz2 || satf) && !sb.flush;
    assign fire    = sb.issue_valid && !stall_c;

    assign inc_any       = fire && sb.issue_wen && (sb.issue_rd != ZERO_REG);
    assign dec_any       = |dec;
    assign underflow_hit = sb.wb_valid && (sb.wb_rd != ZERO_REG) && !nz[sb.wb_rd];

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else if (sb.flush) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_q + INFL_W'(inc_any) - INFL_W'(dec_any);
            if (underflow_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign sb.stall         = stall_c;
    assign sb.issue_fire    = fire;
    assign sb.pending_mask  = nz;
    assign sb.inflight      = inflight_q;
    assign sb.err_underflow = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Directed bench for rf_scoreboard: a per-register count model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_rf_scoreboard;
    import rf_scoreboard_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_scoreboard_if #(.NREG(32), .INFL_W(7)) sb ();

    rf_scoreboard #(.NREG(32), .CNT_W(2), .INFL_W(7)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb)
    );

    int checks   = 0;
    int failures = 0;

    int mcnt [32];
    bit merr    = 1'b0;
    bit started = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // What decode should see this cycle, from the model counts and the current inputs.
    function automatic void m_comb(output bit stall, output bit fire);
        int  e1, e2;
        bit  h1, h2, sat;
        e1  = mcnt[sb.issue_rs1] - ((sb.wb_valid && sb.wb_rd == sb.issue_rs1 && mcnt[sb.issue_rs1] > 0) ? 1 : 0);
        e2  = mcnt[sb.issue_rs2] - ((sb.wb_valid && sb.wb_rd == sb.issue_rs2 && mcnt[sb.issue_rs2] > 0) ? 1 : 0);
        h1  = sb.use_rs1 && sb.issue_rs1 != 0 && e1 != 0;
        h2  = sb.use_rs2 && sb.issue_rs2 != 0 && e2 != 0;
        sat = sb.issue_wen && sb.issue_rd != 0 && mcnt[sb.issue_rd] == 3
              && !(sb.wb_valid && sb.wb_rd == sb.issue_rd);
        stall = sb.issue_valid && (h1 || h2 || sat) && !sb.flush;
        fire  = sb.issue_valid && !stall;
    endfunction

    function automatic logic [31:0] m_mask();
        logic [31:0] m;
        m = '0;
        for (int i = 1; i < 32; i++) m[i] = (mcnt[i] != 0);
        return m;
    endfunction

    function automatic int m_sum();
        int s;
        s = 0;
        for (int i = 0; i < 32; i++) s += mcnt[i];
        return s;
    endfunction

    always @(posedge clk) begin
        bit s, f;
        m_comb(s, f);
        if (reset) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
            merr    = 1'b0;
            started = 1'b1;
        end else if (sb.flush) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
        end else begin
            if (sb.wb_valid && sb.wb_rd != 0 && mcnt[sb.wb_rd] == 0) merr = 1'b1;
            if (sb.wb_valid && sb.wb_rd != 0 && mcnt[sb.wb_rd] > 0) mcnt[sb.wb_rd]--;
            if (f && sb.issue_wen && sb.issue_rd != 0) mcnt[sb.issue_rd]++;
        end
    end

    always @(negedge clk) begin
        bit s, f;
        if (started) begin
            m_comb(s, f);
            chk("m_stall", sb.stall, s);
            chk("m_fire", sb.issue_fire, f);
            chk("m_mask", sb.pending_mask, m_mask());
            chk("m_inflight", sb.inflight, m_sum());
            chk("m_err", sb.err_underflow, merr);
        end
    end

    task automatic idle();
        sb.issue_valid = 0; sb.issue_rs1 = 0; sb.issue_rs2 = 0;
        sb.use_rs1 = 0; sb.use_rs2 = 0; sb.issue_rd = 0; sb.issue_wen = 0;
        sb.wb_valid = 0; sb.wb_rd = 0; sb.flush = 0;
    endtask

    task automatic issue(input reg_addr_t rs1, input logic u1, input reg_addr_t rs2,
                         input logic u2, input reg_addr_t rd, input logic wen);
        sb.issue_valid = 1; sb.issue_rs1 = rs1; sb.use_rs1 = u1;
        sb.issue_rs2 = rs2; sb.use_rs2 = u2; sb.issue_rd = rd; sb.issue_wen = wen;
    endtask

    task automatic wb(input logic v, input reg_addr_t rd);
        sb.wb_valid = v; sb.wb_rd = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        issue(5'd5, 1, 5'd0, 0, 5'd0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", sb.stall, 0);
        chk("rst_mask", sb.pending_mask, 0);
        chk("rst_inflight", sb.inflight, 0);
        chk("rst_err", sb.err_underflow, 0);
        reset = 1'b0;
        idle();

        // single issue to rd=5
        issue(5'd0, 0, 5'd0, 0, 5'd5, 1);
        #1; chk("t1_fire", sb.issue_fire, 1);
        step();
        chk("t1_mask5", sb.pending_mask[5], 1);
        chk("t1_inflight", sb.inflight, 1);

        // RAW on r5 held three cycles, released by same-cycle writeback
        issue(5'd5, 1, 5'd0, 0, 5'd0, 0);
        for (int i = 0; i < 3; i++) begin
            #1; chk("t2_stall", sb.stall, 1);
            step();
        end
        wb(1, 5'd5);
        #1; chk("t2_wb_stall", sb.stall, 0);
        chk("t2_wb_fire", sb.issue_fire, 1);
        step();
        idle();
        chk("t2_mask5", sb.pending_mask[5], 0);
        chk("t2_inflight", sb.inflight, 0);

        // saturate r7
        for (int i = 0; i < 3; i++) begin
            issue(5'd0, 0, 5'd0, 0, 5'd7, 1);
            step();
        end
        #1; chk("t3_satf_stall", sb.stall, 1);
        chk("t3_inflight3", sb.inflight, 3);
        step();
        wb(1, 5'd7);
        #1; chk("t3_wb_fire", sb.issue_fire, 1);
        step();
        idle();
        chk("t3_inflight_keep", sb.inflight, 3);
        chk("t3_mask7", sb.pending_mask[7], 1);

        // register 0 never stalls nor counts
        issue(5'd0, 1, 5'd0, 1, 5'd0, 1);
        #1; chk("t4_stall", sb.stall, 0);
        chk("t4_fire", sb.issue_fire, 1);
        step();
        idle();
        chk("t4_inflight", sb.inflight, 3);
        chk("t4_mask0", sb.pending_mask[0], 0);

        // self-dependency: first passes, repeat stalls on own pending write
        issue(5'd10, 1, 5'd0, 0, 5'd10, 1);
        #1; chk("sd_fire", sb.issue_fire, 1);
        step();
        #1; chk("sd_stall", sb.stall, 1);
        chk("sd_inflight", sb.inflight, 4);
        step();
        idle();

        // flush with pending r3=1, r9=2 and a same-cycle writeback to r3
        issue(5'd0, 0, 5'd0, 0, 5'd3, 1); step();
        issue(5'd0, 0, 5'd0, 0, 5'd9, 1); step();
        issue(5'd0, 0, 5'd0, 0, 5'd9, 1); step();
        idle();
        chk("fl_pre_inflight", sb.inflight, 7);
        sb.flush = 1;
        wb(1, 5'd3);
        issue(5'd7, 1, 5'd0, 0, 5'd0, 0);
        #1; chk("fl_stall", sb.stall, 0);
        step();
        idle();
        chk("fl_inflight", sb.inflight, 0);
        chk("fl_mask", sb.pending_mask, 0);
        chk("fl_err", sb.err_underflow, 0);

        // underflow is sticky through idle and flush
        wb(1, 5'd12);
        step();
        idle();
        chk("uf_err", sb.err_underflow, 1);
        chk("uf_mask12", sb.pending_mask[12], 0);
        chk("uf_inflight", sb.inflight, 0);
        repeat (3) step();
        sb.flush = 1;
        step();
        idle();
        chk("uf_err_hold", sb.err_underflow, 1);

        // reset while stalled
        issue(5'd0, 0, 5'd0, 0, 5'd10, 1); step();
        issue(5'd10, 1, 5'd0, 0, 5'd0, 0);
        #1; chk("rs_stall_pre", sb.stall, 1);
        step();
        reset = 1'b1;
        #1; chk("rs_stall_during", sb.stall, 1);
        step();
        chk("rs_stall_after", sb.stall, 0);
        chk("rs_err", sb.err_underflow, 0);
        reset = 1'b0;
        idle();
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
